// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, arctangent table and gain-compensation
// constant, common to the vectoring (atan2) and rotation (cos/sin) engines.
package cordic_pkg;

   typedef enum logic [1:0] {IDLE, PRE, ITER, POST} cordic_state_t;

   // atan(2^-i) as a fraction of the full circle, scaled by 2^32
   localparam logic [31:0] ATAN_TAB [32] = '{
      32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
      32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
      32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
      32'd166886,    32'd83443,     32'd41722,     32'd20861,
      32'd10430,     32'd5215,      32'd2608,      32'd1304,
      32'd652,       32'd326,       32'd163,       32'd81,
      32'd41,        32'd20,        32'd10,        32'd5,
      32'd3,         32'd1,         32'd1,         32'd0
   };

   // Asymptotic 1/K = prod 1/sqrt(1+2^-2i), scaled by 2^40
   localparam logic [63:0] KINV_INF_Q40 = 64'd667681663043;

   // round(atan(2^-i) * 2^width / (2*pi)), valid for width <= 31
   function automatic logic [31:0] cordic_atan_lut(input logic [4:0] i, input int width);
      logic [63:0] t;
      t = {32'd0, ATAN_TAB[i]} + (64'd1 << (31 - width));
      return 32'(t >> (32 - width));
   endfunction

   // 1/K for n micro-rotations, scaled by 2^width; the finite-n product
   // exceeds the asymptote by a factor of about (1 + (2/3)*4^-n)
   function automatic logic [63:0] cordic_kinv(input int n, input int width);
      logic [63:0] corr;
      corr = ((KINV_INF_Q40 << 1) / 64'd3) >> (2 * n);
      return (KINV_INF_Q40 + corr + (64'd1 << (39 - width))) >> (40 - width);
   endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring-mode micro-rotation: drives y toward zero and
// accumulates the applied rotation into z.
module cordic_vec_step #(
   parameter int W       = 20,
   parameter int SHIFT_W = 5
) (
   input  logic signed [W-1:0]  x,
   input  logic signed [W-1:0]  y,
   input  logic signed [W-1:0]  z,
   input  logic [SHIFT_W-1:0]   shift,
   input  logic signed [W-1:0]  angle,
   output logic signed [W-1:0]  x_next,
   output logic signed [W-1:0]  y_next,
   output logic signed [W-1:0]  z_next
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   always_comb begin
      x_sh = x >>> shift;
      y_sh = y >>> shift;
      if (y[W-1]) begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - angle;
      end else begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + angle;
      end
   end

endmodule

// File: rtl/cordic_atan2.sv
// Serial CORDIC vectoring engine: (x, y) -> (atan2 angle, gain-compensated
// magnitude), one micro-rotation per clock.
module cordic_atan2
   import cordic_pkg::*;
#(
   parameter int N         = 13,
   parameter int PHI_WIDTH = 18
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        st,
   input  logic signed [PHI_WIDTH-1:0] x,
   input  logic signed [PHI_WIDTH-1:0] y,
   output logic                        rdy,
   output logic                        busy,
   output logic [PHI_WIDTH-1:0]        phi,
   output logic [PHI_WIDTH:0]          mag
);

   localparam int W  = PHI_WIDTH + 2;
   localparam int PW = W + PHI_WIDTH + 1;
   localparam logic [63:0]          KINV_Q  = cordic_kinv(N, PHI_WIDTH + 1);
   localparam logic [PHI_WIDTH:0]   KINV    = KINV_Q[PHI_WIDTH:0];
   localparam logic [PHI_WIDTH:0]   MAG_MAX = '1;
   localparam logic signed [W-1:0]  Z_PI    = {1'b1, {(W-1){1'b0}}};

   cordic_state_t state, state_nxt;
   logic [4:0]          cnt;
   logic signed [W-1:0] xr, yr, zr;
   logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
   logic signed [W-1:0] angle;
   logic                zero_in;

   // Drop the two guard bits with round-half-up; overflow wraps modulo 2*pi.
   function automatic logic [PHI_WIDTH-1:0] round_phi(input logic signed [W-1:0] z);
      logic [W-1:0] t;
      t = z + W'(2);
      return t[W-1:2];
   endfunction

   function automatic logic [PHI_WIDTH:0] scale_mag(input logic signed [W-1:0] xv);
      logic [PW-1:0]      prod;
      logic [PW-1:0]      q;
      logic [PHI_WIDTH:0] res;
      prod = PW'($unsigned(xv)) * PW'(KINV) + (PW'(1) << PHI_WIDTH);
      q    = prod >> (PHI_WIDTH + 1);
      if (xv[W-1])
         res = '0;
      else if (q > PW'(MAG_MAX))
         res = MAG_MAX;
      else
         res = q[PHI_WIDTH:0];
      return res;
   endfunction

   assign angle = W'(cordic_atan_lut(cnt, W));
   assign busy  = (state != IDLE) || rdy;

   cordic_vec_step #(.W(W), .SHIFT_W(5)) u_step (
      .x      (xr),
      .y      (yr),
      .z      (zr),
      .shift  (cnt),
      .angle  (angle),
      .x_next (x_nxt),
      .y_next (y_nxt),
      .z_next (z_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (st) state_nxt = PRE;
         PRE:     state_nxt = ITER;
         ITER:    if (cnt == 5'(N - 1)) state_nxt = POST;
         POST:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         rdy <= 1'b0;
         phi <= '0;
         mag <= '0;
      end else begin
         rdy <= (state == POST);
         cnt <= (state == ITER) ? cnt + 5'd1 : 5'd0;
         if (state == POST) begin
            phi <= zero_in ? '0 : round_phi(zr);
            mag <= zero_in ? '0 : scale_mag(xr);
         end
      end
   end

   // Working registers carry no reset; each conversion reloads them from IDLE.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (st) begin
            xr <= {{2{x[PHI_WIDTH-1]}}, x};
            yr <= {{2{y[PHI_WIDTH-1]}}, y};
         end
         PRE: begin
            zero_in <= (xr == '0) && (yr == '0);
            if (xr[W-1]) begin
               xr <= -xr;
               yr <= -yr;
               zr <= Z_PI;
            end else begin
               zr <= '0;
            end
         end
         ITER: begin
            xr <= x_nxt;
            yr <= y_nxt;
            zr <= z_nxt;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cordic_atan2.sv
// Scoreboard bench for cordic_atan2: expected polar results come from a
// floating-point atan2/sqrt model and are compared when rdy pulses.
module tb_cordic_atan2;

   localparam int  NI    = 13;
   localparam int  PW    = 18;
   localparam int  FULL  = 262144;
   localparam real M_PI  = 3.14159265358979323846;
   localparam real SCALE = 262144.0 / (2.0 * M_PI);

   logic                 clk   = 1'b0;
   logic                 reset = 1'b1;
   logic                 st    = 1'b0;
   logic signed [PW-1:0] x_i   = '0;
   logic signed [PW-1:0] y_i   = '0;
   logic                 rdy;
   logic                 busy;
   logic [PW-1:0]        phi;
   logic [PW:0]          mag;

   typedef struct {
      int  phi;
      int  mag;
      real phi_tol;
      real mag_tol;
      int  t0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   last_phi = 0;
   int   last_mag = 0;
   real  last_ptol = 0.0;
   real  last_mtol = 0.0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_atan2 #(.N(NI), .PHI_WIDTH(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .st    (st),
      .x     (x_i),
      .y     (y_i),
      .rdy   (rdy),
      .busy  (busy),
      .phi   (phi),
      .mag   (mag)
   );

   task automatic chk(input string tag, input int obs, input int want, input real tol, input bit wrap);
      int d;
      n_chk++;
      d = obs - want;
      if (wrap) begin
         if (d > FULL / 2) d -= FULL;
         else if (d < -FULL / 2) d += FULL;
      end
      if (real'(d) > tol || real'(d) < -tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (+/-%0.2f) at cycle %0d", tag, obs, want, tol, cyc);
      end
   endtask

   function automatic exp_t model(input int xv, input int yv, input real ptol, input real mtol, input int t0);
      exp_t e;
      real  a;
      a = $atan2(real'(yv), real'(xv));
      if (a < 0.0) a += 2.0 * M_PI;
      e.phi = int'(a * SCALE);
      if (e.phi >= FULL) e.phi -= FULL;
      e.mag = int'($sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)));
      e.phi_tol = ptol;
      e.mag_tol = mtol;
      e.t0 = t0;
      return e;
   endfunction

   // Drive a start pulse from the current (negative-edge) time for one cycle.
   task automatic start(input int xv, input int yv, input real ptol, input real mtol, input bit accept);
      x_i = PW'(xv);
      y_i = PW'(yv);
      st  = 1'b1;
      if (accept) sb.push_back(model(xv, yv, ptol, mtol, cyc + 1));
      @(negedge clk);
      st = 1'b0;
      if (accept) chk("busy_after_st", int'(busy), 1, 0.0, 1'b0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 4 * NI && sb.size() != 0; i++) @(negedge clk);
      chk("done_timeout", sb.size(), 0, 0.0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rdy) begin
         if (sb.size() == 0) begin
            chk("spurious_rdy", 1, 0, 0.0, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("phi", int'(phi), mon_e.phi, mon_e.phi_tol, 1'b1);
            chk("mag", int'(mag), mon_e.mag, mon_e.mag_tol, 1'b0);
            chk("latency", cyc - mon_e.t0, NI + 2, 0.0, 1'b0);
            chk("busy_at_rdy", int'(busy), 1, 0.0, 1'b0);
            last_phi  = mon_e.phi;
            last_mag  = mon_e.mag;
            last_ptol = mon_e.phi_tol;
            last_mtol = mon_e.mag_tol;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  xv, yv, ta, tb;
      real r, ptol_spec, mtol_spec;
      int  card_x[6] = '{100000, 0, -100000, 0, -131072, 131071};
      int  card_y[6] = '{0, 100000, 0, -100000, 0, -3};

      ptol_spec = $atan(2.0 ** (-(NI - 1))) * SCALE + 2.0;

      repeat (3) @(negedge clk);
      chk("reset_rdy", int'(rdy), 0, 0.0, 1'b0);
      chk("reset_busy", int'(busy), 0, 0.0, 1'b0);
      chk("reset_phi", int'(phi), 0, 0.0, 1'b0);
      chk("reset_mag", int'(mag), 0, 0.0, 1'b0);
      reset = 1'b0;

      // cardinal angles plus the pi and 2*pi wrap neighbourhoods
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start(card_x[k], card_y[k], 12.0, 3.0, 1'b1);
         wait_done();
      end

      repeat (3) @(negedge clk);
      chk("phi_hold", int'(phi), last_phi, last_ptol, 1'b1);
      chk("mag_hold", int'(mag), last_mag, last_mtol, 1'b0);
      chk("busy_idle", int'(busy), 0, 0.0, 1'b0);

      @(negedge clk);
      start(-131072, -131072, 12.0, 4.0, 1'b1);
      wait_done();

      @(negedge clk);
      start(0, 0, 0.0, 0.0, 1'b1);
      wait_done();

      // back-to-back: second start lands in the rdy cycle of the first
      @(negedge clk);
      ta = cyc + 1;
      start(30000, 40000, ptol_spec, 50000.0 / 8192.0 + 2.0, 1'b1);
      for (int i = 0; i < 4 * NI && !rdy; i++) @(negedge clk);
      tb = cyc + 1;
      start(-50000, 20000, ptol_spec, 53852.0 / 8192.0 + 2.0, 1'b1);
      chk("b2b_gap", tb - ta, NI + 3, 0.0, 1'b0);
      wait_done();

      // a start mid-conversion must be ignored and produce no extra rdy
      @(negedge clk);
      start(70000, -70000, ptol_spec, 98995.0 / 8192.0 + 2.0, 1'b1);
      repeat (4) @(negedge clk);
      chk("busy_mid", int'(busy), 1, 0.0, 1'b0);
      start(-90000, 5000, 0.0, 0.0, 1'b0);
      wait_done();
      repeat (NI + 5) @(negedge clk);

      // asynchronous reset during iteration 5
      @(negedge clk);
      start(50000, 80000, ptol_spec, 94340.0 / 8192.0 + 2.0, 1'b1);
      repeat (5) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_rdy", int'(rdy), 0, 0.0, 1'b0);
      chk("rst_mid_busy", int'(busy), 0, 0.0, 1'b0);
      chk("rst_mid_phi", int'(phi), 0, 0.0, 1'b0);
      chk("rst_mid_mag", int'(mag), 0, 0.0, 1'b0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      start(-20000, -110000, ptol_spec, 111804.0 / 8192.0 + 2.0, 1'b1);
      wait_done();

      // random sweep over vectors of usable magnitude
      for (int n = 0; n < 150; n++) begin
         do begin
            xv = int'($urandom_range(262143, 0)) - 131072;
            yv = int'($urandom_range(262143, 0)) - 131072;
            r  = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
         end while (r < 32768.0);
         mtol_spec = r / 8192.0 + 2.0;
         @(negedge clk);
         start(xv, yv, ptol_spec, mtol_spec, 1'b1);
         wait_done();
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
